// File: rtl/match_sched.sv
// Frame sequencer for the binary template matcher: drives the line-buffer advance,
// sums per-row mismatch scores into TROWS-row windows and reports the lowest window.
`timescale 1ns/1ps
module match_sched #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int TROWS     = 40,
  parameter int PRIME_CYC = 2,
  parameter int SW        = 7,
  parameter int AW        = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          pause,
  output logic          busy,
  output logic          lb_stall,
  input  logic          lb_valid,
  input  logic [9:0]    lb_xpos,
  input  logic [9:0]    lb_ypos,
  input  logic          lb_mark,
  input  logic [SW-1:0] score_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_found,
  output logic [AW-1:0] res_score,
  output logic [9:0]    res_x,
  output logic [9:0]    res_y
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX);
  localparam int RW   = $clog2(TROWS + 2);
  localparam int CW   = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;

  localparam logic [PW-1:0] LAST_PIX  = PW'(NPIX - 1);
  localparam logic [RW-1:0] ROW_FULL  = RW'(TROWS);
  localparam logic [RW-1:0] ROW_SAT   = RW'(TROWS + 1);
  localparam logic [CW-1:0] PRIME_END = CW'(PRIME_CYC - 1);
  localparam logic [SW-1:0] SCORE_MAX = SW'(100);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_pix_cnt;
  logic [CW-1:0] r_prime_cnt;
  logic [AW-1:0] r_acc;
  logic [RW-1:0] r_row_cnt;
  logic          r_win_ok;
  logic [9:0]    r_win_x;
  logic [9:0]    r_win_y;
  logic [AW-1:0] r_best;
  logic [9:0]    r_best_x;
  logic [9:0]    r_best_y;
  logic          r_found;

  logic [SW-1:0] w_score_c;
  logic          w_last;
  logic [AW-1:0] w_acc_n;
  logic [RW-1:0] w_row_n;
  logic          w_ok_n;
  logic [9:0]    w_win_x_n;
  logic [9:0]    w_win_y_n;
  logic [AW-1:0] w_best_n;
  logic [9:0]    w_best_x_n;
  logic [9:0]    w_best_y_n;
  logic          w_found_n;

  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign res_found = r_found;
  assign res_score = r_best;
  assign res_x     = r_best_x;
  assign res_y     = r_best_y;

  always_comb begin
    unique case (r_state)
      S_PRIME: lb_stall = 1'b0;
      S_RUN:   lb_stall = pause;
      default: lb_stall = 1'b1;
    endcase
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    w_score_c  = (score_in > SCORE_MAX) ? SCORE_MAX : score_in;
    w_last     = (r_pix_cnt == LAST_PIX);
    w_acc_n    = r_acc + AW'(w_score_c);
    w_row_n    = (r_row_cnt == ROW_SAT) ? r_row_cnt : r_row_cnt + 1'b1;
    w_ok_n     = r_win_ok & lb_valid;
    w_win_x_n  = r_win_x;
    w_win_y_n  = r_win_y;
    w_best_n   = r_best;
    w_best_x_n = r_best_x;
    w_best_y_n = r_best_y;
    w_found_n  = r_found;
    if (lb_mark) begin
      w_acc_n   = AW'(w_score_c);
      w_row_n   = RW'(1);
      w_ok_n    = lb_valid;
      w_win_x_n = lb_xpos;
      w_win_y_n = lb_ypos;
      if (r_row_cnt == ROW_FULL && r_win_ok && r_acc < r_best) begin
        w_best_n   = r_acc;
        w_best_x_n = r_win_x;
        w_best_y_n = r_win_y;
        w_found_n  = 1'b1;
      end
    end
    // The last pixel closes the window it just extended, scored against the updated best.
    if (w_last && w_row_n == ROW_FULL && w_ok_n && w_acc_n < w_best_n) begin
      w_best_n   = w_acc_n;
      w_best_x_n = w_win_x_n;
      w_best_y_n = w_win_y_n;
      w_found_n  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pix_cnt   <= '0;
      r_prime_cnt <= '0;
      r_acc       <= '0;
      r_row_cnt   <= '0;
      r_win_ok    <= 1'b0;
      r_win_x     <= '0;
      r_win_y     <= '0;
      r_best      <= '1;
      r_best_x    <= '0;
      r_best_y    <= '0;
      r_found     <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_PRIME;
            r_pix_cnt   <= '0;
            r_prime_cnt <= '0;
            r_acc       <= '0;
            r_row_cnt   <= '0;
            r_win_ok    <= 1'b0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            r_best      <= '1;
            r_best_x    <= '0;
            r_best_y    <= '0;
            r_found     <= 1'b0;
          end
        end
        S_PRIME: begin
          if (r_prime_cnt == PRIME_END) r_state <= S_RUN;
          else                          r_prime_cnt <= r_prime_cnt + 1'b1;
        end
        S_RUN: begin
          if (!pause) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
            r_acc     <= w_acc_n;
            r_row_cnt <= w_row_n;
            r_win_ok  <= w_ok_n;
            r_win_x   <= w_win_x_n;
            r_win_y   <= w_win_y_n;
            r_best    <= w_best_n;
            r_best_x  <= w_best_x_n;
            r_best_y  <= w_best_y_n;
            r_found   <= w_found_n;
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
